// File: rtl/hazard_pkg.sv
// Shared constants and compare helpers for the pipeline hazard controller.
package hazard_pkg;

    // D-stage operand select
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;

    // E-stage operand select
    localparam logic [1:0] FWD_EM = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int MD_CNT_W        = 4;

    // A producer still in flight whose result arrives after the consumer needs it.
    function automatic logic raw_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_waddr,
        input logic [1:0] e_tnew,
        input logic [4:0] m_waddr,
        input logic [1:0] m_tnew
    );
        return (src != 5'd0) &&
               (((src == e_waddr) && (tuse < e_tnew)) ||
                ((src == m_waddr) && (tuse < m_tnew)));
    endfunction

    function automatic logic [1:0] d_fwd_sel(
        input logic [4:0] src,
        input logic [4:0] e_waddr,
        input logic [1:0] e_tnew,
        input logic [4:0] m_waddr,
        input logic [1:0] m_tnew
    );
        if (src == 5'd0)                             return FWD_RF;
        else if ((src == e_waddr) && (e_tnew == 2'd0)) return FWD_E;
        else if ((src == m_waddr) && (m_tnew == 2'd0)) return FWD_M;
        else                                         return FWD_RF;
    endfunction

    function automatic logic [1:0] e_fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_waddr,
        input logic [1:0] m_tnew,
        input logic [4:0] w_waddr
    );
        if (src == 5'd0)                             return FWD_RF;
        else if ((src == m_waddr) && (m_tnew == 2'd0)) return FWD_EM;
        else if (src == w_waddr)                     return FWD_W;
        else                                         return FWD_RF;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy counter: loads the operation latency on a start and
// counts down to zero; md_busy covers the start cycle plus every nonzero count.
module md_busy_cnt
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [MD_CNT_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, regardless of block ordering in simulation.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (count != '0)
            count <= count - 1'b1;  // a start while counting is ignored
        else if (start)
            count <= is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
    end

    assign busy = !reset && (start || (count != '0));

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller with operand forwarding selects.
// Optional macro STALL_CNT_EN adds a free-running 32-bit stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_md_use,
    input  logic [4:0]  E_rs,
    input  logic [4:0]  E_rt,
    input  logic [4:0]  E_waddr,
    input  logic [4:0]  M_waddr,
    input  logic [4:0]  W_waddr,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        F_pcWE,
    output logic        D_regWE,
    output logic        E_flush,
    output logic        stall,
    output logic        md_busy,
    output logic [1:0]  D_fwd_rs,
    output logic [1:0]  D_fwd_rt,
    output logic [1:0]  E_fwd_rs,
    output logic [1:0]  E_fwd_rt,
    output logic [31:0] stall_cnt
);

    logic stall_rs, stall_rt, stall_md;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_div),
        .busy   (md_busy)
    );

    // NOTE: combinational block assigns every output a default first so no
    // path through it can leave a value held, which would infer a latch.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        stall_md = 1'b0;
        stall    = 1'b0;
        if (!reset) begin
            stall_rs = raw_hazard(D_rs, D_tuse_rs, E_waddr, E_tnew, M_waddr, M_tnew);
            stall_rt = raw_hazard(D_rt, D_tuse_rt, E_waddr, E_tnew, M_waddr, M_tnew);
            stall_md = D_md_use && md_busy;
            stall    = stall_rs || stall_rt || stall_md;
        end
    end

    assign F_pcWE  = !stall;
    assign D_regWE = !stall;
    assign E_flush = stall;

    // Writeback-to-D is bypassed inside the register file, so D only looks at E and M.
    assign D_fwd_rs = d_fwd_sel(D_rs, E_waddr, E_tnew, M_waddr, M_tnew);
    assign D_fwd_rt = d_fwd_sel(D_rt, E_waddr, E_tnew, M_waddr, M_tnew);
    assign E_fwd_rs = e_fwd_sel(E_rs, M_waddr, M_tnew, W_waddr);
    assign E_fwd_rt = e_fwd_sel(E_rt, M_waddr, M_tnew, W_waddr);

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (stall)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It generates the write enables and flushes that sequence the F/D/E pipeline registers: PC write enable, D-register write enable and E-register flush. It also produces forwarding selects for the D and E stage operand muxes. It contains a multi-cycle multiply/divide busy counter that stalls MDU-dependent instructions held in D.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- D_rs, D_rt  in  5 each  source registers of the D instruction
- D_tuse_rs, D_tuse_rt  in  2 each  cycles until the operand is needed; 3 = unused
- D_md_use  in  1  D instruction accesses the MDU or HI/LO
- E_rs, E_rt  in  5 each  source registers of the E instruction
- E_waddr, M_waddr, W_waddr  in  5 each  destination register; 0 = no write
- E_tnew, M_tnew  in  2 each  cycles until the result is available at that stage
- E_md_start  in  1  E instruction starts an MDU operation this cycle
- E_md_div  in  1  with E_md_start: 1 = divide, 0 = multiply
- F_pcWE  out  1  PC write enable
- D_regWE  out  1  D-register write enable
- E_flush  out  1  load a bubble (zeros) into the E register
- stall  out  1  composite stall
- md_busy  out  1  MDU busy
- D_fwd_rs, D_fwd_rt  out  2 each  0 = regfile, 1 = from E, 2 = from M
- E_fwd_rs, E_fwd_rt  out  2 each  0 = register value, 1 = from M, 2 = from W
- stall_cnt  out  32  stall-cycle count

## Operation
- Data stall for rs: D_rs != 0 and either of the following holds:
  - D_rs == E_waddr and D_tuse_rs < E_tnew
  - D_rs == M_waddr and D_tuse_rs < M_tnew
- Data stall for rt: the same rules using D_rt and D_tuse_rt.
- MDU stall: D_md_use && md_busy.
- stall = data stall (rs or rt) OR MDU stall.
- Outputs derived from stall:
  - F_pcWE = D_regWE = !stall
  - E_flush = stall
- D forwarding: select 1 if the source register is nonzero, equals E_waddr and E_tnew == 0; else select 2 if it equals M_waddr and M_tnew == 0; else select 0. E has priority over M.
- E forwarding: select 1 if the source register is nonzero, equals M_waddr and M_tnew == 0; else select 2 if it equals W_waddr; else select 0. M has priority over W.
- Writeback-to-D forwarding is not generated here; the register file bypasses internally.
- MDU counter behaviour:
  - When E_md_start is high and the count is 0, the 4-bit count loads DIV_CYCLES (if E_md_div) or MULT_CYCLES.
  - When the count is nonzero it decrements every cycle.
  - md_busy = E_md_start OR (count != 0).
  - E_md_start while the count is nonzero is ignored: no reload.
- While reset is high, stall, E_flush and md_busy are forced to 0, and F_pcWE and D_regWE are forced to 1.

## Timing
- Every output except md_busy and stall_cnt is combinational from the same-cycle inputs.
- The register loads happen on the clk edge, so the stall takes effect that cycle.
- Reset values: count = 0, stall_cnt = 0, md_busy = 0.
- MDU start in cycle t:
  - The count holds MULT_CYCLES..1 during cycles t+1..t+5.
  - md_busy is high for cycles t..t+5, which is 6 cycles for a multiply (11 for a divide).
  - The first cycle in which an MDU consumer in D can advance is t+6.
- Boundaries:
  - At count == 1, md_busy is still high; it releases at the next edge.
  - Simultaneous data and MDU stall produce a single stall.
  - Reset asserted mid-count clears the count at that edge.
  - A register address of 0 never stalls and never forwards.

## Configuration
- STALL_CNT_EN defined: stall_cnt increments by 1 on every edge where stall = 1 and reset = 0. It wraps at 2^32.
- STALL_CNT_EN undefined: stall_cnt is a constant 0 and no counter register is present.

## Structure
- Package hazard_pkg holds:
  - FWD_RF = 0, FWD_E = 1, FWD_M = 2
  - FWD_EM = 1, FWD_W = 2
  - TUSE_NONE = 3
  - The default MULT_CYCLES and DIV_CYCLES values
- Sub-module md_busy_cnt contains the load/decrement counter and the md_busy generation. The stall and forwarding compare logic stays in the top level.

## Test plan
- RAW on rs with load-use: D_rs = 8, D_tuse_rs = 0, E_waddr = 8, E_tnew = 2 -> stall = 1, F_pcWE = 0, D_regWE = 0, E_flush = 1. Then with M_waddr = 8, M_tnew = 1 on the next cycle -> stall = 1. Then M_tnew = 0 -> stall = 0, D_fwd_rs = 2.
- Forward priority: E_waddr = M_waddr = 5, both tnew = 0, D_rt = 5, D_tuse_rt = 1 -> D_fwd_rt = 1, stall = 0. With E_rs = 5 and W_waddr = 5 -> E_fwd_rs = 1.
- Register 0: D_rs = 0, E_waddr = 0, E_tnew = 2, D_tuse_rs = 0 -> stall = 0, D_fwd_rs = 0.
- Multiply: E_md_start = 1, E_md_div = 0 in cycle 0, then D_md_use held at 1 -> stall = 1 in cycles 0..5 and stall = 0 in cycle 6. A divide gives stall = 1 in cycles 0..10.
- Reset mid-divide: reset asserted in cycle 3 after a div start -> md_busy = 0 from cycle 4, stall_cnt = 0.
- With STALL_CNT_EN: 4 data-stall cycles from reset -> stall_cnt = 4. Without the macro -> stall_cnt = 0.
